down_timer_arbiter: RTL
=======================

// Module: down_timer_arbiter
// PURPOSE
//  Shares one 4-bit synchronous down-count timer among N_REQ requesters.
//  - Each requester asks for a delay of N ticks.
//  - Round-robin arbitration picks one requester, loads its delay and counts
//    down on tick_en, then pulses that requester's done line.
//  - Sits between control FSMs that need timed waits and the shared counter
//    resource, so each FSM does not need its own counter.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  CNT_W  4  timer width; delay range 0..2**CNT_W-1
// PORTS
//  clk      in   1            system clock, all state on rising edge
//  rst      in   1            asynchronous, active-low reset (0 = reset)
//  req      in   N_REQ        per-requester timer request; hold until done or abort
//  delay    in   N_REQ*CNT_W  delay for requester i = delay[i*CNT_W +: CNT_W]
//  tick_en  in   1            count enable (prescaler strobe); 1 = decrement this cycle
//  grant    out  N_REQ        one-hot owner of timer; 0 when idle
//  done     out  N_REQ        one-hot, 1-cycle pulse: owner's delay expired
//  busy     out  1            timer owned (state RUN or DONE)
//  count    out  CNT_W        current timer value
// BEHAVIOUR
//  Reset (rst=0, async):
//  - state=IDLE, count=0, grant=0, done=0, busy=0, rr pointer=0.
//  - All outputs are registered.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: if |req, the winner is the first set bit searching from pointer
//    upward, wrapping modulo N_REQ. On that edge:
//    - grant <= onehot(w); count <= delay[w]; state <= RUN.
//    - If no req, stay in IDLE and hold count.
//  - RUN:
//    - If req[w]==0 (abort): next edge grant <= 0, state <= IDLE,
//      pointer <= (w+1)%N_REQ, no done. Abort has priority over expiry.
//    - Else if count==0: state <= DONE, done <= onehot(w).
//    - Else if tick_en: count <= count-1.
//    - Else: hold.
//    - tick_en is ignored once count==0; a zero-delay expires on the first
//      RUN cycle.
//  - DONE:
//    - done and grant are both high for exactly one cycle.
//    - Next edge: done <= 0, grant <= 0, state <= IDLE,
//      pointer <= (w+1)%N_REQ.
//  Latency with tick_en held at 1:
//  - The grant edge is cycle 0; done is high during cycle D+1.
//  - There is always at least one IDLE cycle between consecutive grants.
//  Count arithmetic:
//  - count never wraps: it holds at 0 and never reloads below 0.
//  - delay is sampled only at the grant edge. Later changes to delay are
//    ignored until the next grant.
//  Ownership and fairness:
//  - Requests that arrive during RUN or DONE wait; they do not preempt.
//  - A requester that keeps req high after done is rearbitrated normally.
//  - Its pointer has moved past it, so no requester starves: worst-case wait
//    is (N_REQ-1) full timings.
//  Reset mid-operation: return immediately to reset values. No done pulse is
//  emitted and the pending request is lost.
//  busy == (state != IDLE); grant is one-hot or zero at all times.
// TESTING
//  1. Reset, then req=0001, delay0=3, tick_en=1 -> grant=0001 next edge;
//     count 3,2,1,0; done=0001 in cycle 4; grant=0 in cycle 5.
//  2. Requests on 0 and 2 from idle, delays 2 and 1 -> serve 0 then 2.
//     Then requests on 0,1,2 -> order is 0,1,2 (pointer after 2 is 3, wrap).
//  3. delay=0 -> done one cycle after grant. delay=15 -> done 16 cycles after
//     grant. count never goes below 0.
//  4. delay=4, tick_en=1 on every 3rd cycle -> done one cycle after the 4th
//     strobe; count holds between strobes.
//  5. Abort: drop req[1] at count=2 -> IDLE next edge, done stays 0, and the
//     pending req[3] is granted one cycle later.
//  6. Drive rst=0 asynchronously mid-RUN (count=5) -> grant, done, busy and
//     count go to 0 before the next clock edge; normal operation after release.
//  Bench also checks every cycle: grant one-hot or 0; done set only while the
//  matching grant is set; busy == |grant.

Source files
------------

// File: rtl/down_timer_arbiter.sv
// down_timer_arbiter: one shared down-count timer served to N_REQ requesters by
// round-robin arbitration. The winner's delay is loaded at the grant edge and
// counted down on tick_en. The owner's done line then pulses for one cycle.
//
// Ports:
//   clk      system clock, all state on rising edge
//   rst      asynchronous active-low reset
//   req      per-requester timer request, held until done or dropped to abort
//   delay    packed delays, requester i uses delay[i*CNT_W +: CNT_W]
//   tick_en  count enable strobe
//   grant    one-hot timer owner, zero when idle
//   done     one-hot single-cycle expiry pulse for the owner
//   busy     timer owned (RUN or DONE)
//   count    current timer value
module down_timer_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] delay,
    input  logic                   tick_en,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       count
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] win_delay;
    logic [IDX_W-1:0] next_ptr;

    // First set request at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        win_delay = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_valid && req[IDX_W'(idx)]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(idx);
                win_delay = delay[idx*CNT_W +: CNT_W];
            end
        end
    end

    // Pointer moves just past the owner whenever ownership ends.
    always_comb begin
        next_ptr = '0;
        if (owner != IDX_W'(N_REQ - 1)) begin
            next_ptr = owner + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StIdle;
            ptr   <= '0;
            owner <= '0;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= '0;
                    if (win_valid) begin
                        grant          <= '0;
                        grant[win_idx] <= 1'b1;
                        owner          <= win_idx;
                        count          <= win_delay;
                        busy           <= 1'b1;
                        state          <= StRun;
                    end
                end
                StRun: begin
                    if (!req[owner]) begin
                        // Abort wins over expiry; no done pulse.
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                        state <= StIdle;
                    end else if (count == '0) begin
                        done  <= grant;
                        state <= StDone;
                    end else if (tick_en) begin
                        count <= count - CNT_W'(1);
                    end
                end
                StDone: begin
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= next_ptr;
                    state <= StIdle;
                end
                default: begin
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
